// File: rtl/mont_pkg.sv
// rtl/mont_pkg.sv - shared widths and FSM state type for the Montgomery datapath
package mont_pkg;
   localparam int EXP_W   = 13;
   localparam int MSIZE_W = 12;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;
endpackage

// File: rtl/r_red_precompute_if.sv
// rtl/r_red_precompute_if.sv - start/operand/result bundle for r_red_precompute
interface r_red_precompute_if import mont_pkg::*; #(parameter int NBITS = 2048);
   logic               enable_p;
   logic [NBITS-1:0]   m;
   logic [MSIZE_W-1:0] m_size;
   logic               sq_sel;
   logic [NBITS-1:0]   y;
   logic               busy;
   logic               err;
   logic               done_irq_p;

   modport master (
      output enable_p, m, m_size, sq_sel,
      input  y, busy, err, done_irq_p
   );

   modport slave (
      input  enable_p, m, m_size, sq_sel,
      output y, busy, err, done_irq_p
   );
endinterface

// File: rtl/r_red_precompute_mod_dbl_step.sv
// rtl/r_red_precompute_mod_dbl_step.sv - one modular doubling: (2*acc_in) mod m, acc_in < m
module mod_dbl_step #(
   parameter int NBITS = 2048
) (
   input  logic [NBITS-1:0] acc_in,
   input  logic [NBITS-1:0] m,
   output logic [NBITS-1:0] acc_out
);
   logic [NBITS:0] t2;
   logic [NBITS:0] diff;

   assign t2   = {acc_in, 1'b0};
   assign diff = t2 - {1'b0, m};
   // With acc_in < m, t2 - m < m when no borrow, so the top bit of diff is a clean borrow flag.
   assign acc_out = diff[NBITS] ? t2[NBITS-1:0] : diff[NBITS-1:0];
endmodule

// File: rtl/r_red_precompute.sv
// rtl/r_red_precompute.sv - computes r_red = 2^e mod m by iterated modular doubling
module r_red_precompute import mont_pkg::*; #(
   parameter int NBITS = 2048,
   parameter int PBITS = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   r_red_precompute_if.slave  bus
);
   localparam logic [NBITS-1:0] ONE = {{(NBITS-1){1'b0}}, 1'b1};

   state_t           state;
   logic [NBITS-1:0] m_q;
   logic [NBITS-1:0] acc;
   logic [NBITS-1:0] y_q;
   logic [EXP_W-1:0] cnt;
   logic             busy_q;
   logic             err_q;
   logic             done_q;
   logic             err_hold;

   logic [NBITS-1:0] chain [0:PBITS];
   logic [NBITS-1:0] acc_nxt;
   logic [EXP_W-1:0] d;
   logic [EXP_W-1:0] cnt_nxt;
   logic [EXP_W-1:0] e_in;
   logic             bad;

   assign chain[0] = acc;

   genvar k;
   generate
      for (k = 0; k < PBITS; k++) begin : g_step
         mod_dbl_step #(.NBITS(NBITS)) u_step (
            .acc_in  (chain[k]),
            .m       (m_q),
            .acc_out (chain[k+1])
         );
      end
   endgenerate

   always_comb begin
      d = (cnt < EXP_W'(PBITS)) ? cnt : EXP_W'(PBITS);
      cnt_nxt = cnt - d;
      acc_nxt = acc;
      for (int i = 0; i < PBITS; i++) begin
         if (EXP_W'(i) < d) acc_nxt = chain[i+1];
      end
   end

   assign e_in = bus.sq_sel ? {bus.m_size, 1'b0} : {1'b0, bus.m_size};
   assign bad  = (bus.m == '0) || (int'(bus.m_size) > NBITS);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         m_q      <= '0;
         acc      <= '0;
         y_q      <= '0;
         cnt      <= '0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
         err_hold <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.enable_p) begin
                  m_q    <= bus.m;
                  cnt    <= e_in;
                  busy_q <= 1'b1;
                  err_q  <= bad;
                  if (bad) begin
                     acc      <= '0;
                     err_hold <= 1'b1;
                     state    <= ST_DONE;
                  end else begin
                     acc   <= (bus.m == ONE) ? '0 : ONE;
                     state <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               acc <= acc_nxt;
               cnt <= cnt_nxt;
               if (cnt_nxt == '0) state <= ST_DONE;
            end
            ST_DONE: begin
               // Error path dwells one extra cycle so it completes two edges after the start.
               if (err_hold) begin
                  err_hold <= 1'b0;
               end else begin
                  y_q    <= err_q ? '0 : acc;
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.y          = y_q;
   assign bus.busy       = busy_q;
   assign bus.err        = err_q;
   assign bus.done_irq_p = done_q;
endmodule

// File: tb/tb_r_red_precompute.sv
// tb/tb_r_red_precompute.sv - self-checking bench: PBITS=1 and PBITS=3 instances, NBITS=64
module tb_r_red_precompute;
   localparam int NB = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   logic [NB-1:0] prev_y = '0;

   r_red_precompute_if #(.NBITS(NB)) if1 ();
   r_red_precompute_if #(.NBITS(NB)) if3 ();

   r_red_precompute #(.NBITS(NB), .PBITS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
   r_red_precompute #(.NBITS(NB), .PBITS(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [NB-1:0] m;
      int            ms;
      bit            sq;
      logic [NB-1:0] exp_y;
      bit            exp_err;
   } vec_t;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [NB-1:0] ref_pow2(input logic [NB-1:0] m, input int e);
      logic [127:0] r;
      if (m == 0) return '0;
      r = 128'd1 % m;
      for (int i = 0; i < e; i++) r = (r * 2) % m;
      return r[NB-1:0];
   endfunction

   function automatic int ref_lat(input bit is_err, input int e, input int p);
      int n;
      if (is_err) return 2;
      n = (e + p - 1) / p;
      if (n < 1) n = 1;
      return n + 1;
   endfunction

   task automatic drive(input logic [NB-1:0] m, input int ms, input bit sq, input bit en);
      if1.m = m;  if1.m_size = ms[11:0]; if1.sq_sel = sq; if1.enable_p = en;
      if3.m = m;  if3.m_size = ms[11:0]; if3.sq_sel = sq; if3.enable_p = en;
   endtask

   // Called at a negedge; returns at the negedge where the slower instance shows done.
   task automatic run_op(input logic [NB-1:0] m, input int ms, input bit sq, input bit disturb,
                         output logic [NB-1:0] y1, output logic [NB-1:0] y3,
                         output bit e1, output bit e3);
      int  t, e, l1, l3;
      bit  s1, s3, is_err;
      is_err = (m == 0) || (ms > NB);
      e = sq ? 2 * ms : ms;
      s1 = 0; s3 = 0; y1 = '0; y3 = '0; e1 = 0; e3 = 0; l1 = 0; l3 = 0;
      drive(m, ms, sq, 1'b1);
      t = cyc + 1;
      for (int i = 0; i < 400 && !(s1 && s3); i++) begin
         @(negedge clk);
         if (i == 0) begin
            chk("busy_after_start1", if1.busy, 1);
            chk("busy_after_start3", if3.busy, 1);
            chk("y_held1", if1.y, prev_y);
            if1.enable_p = 1'b0; if3.enable_p = 1'b0;
         end
         if (disturb && i == 2) drive(64'd7, 3, 1'b0, 1'b1);
         if (disturb && i == 3) begin if1.enable_p = 1'b0; if3.enable_p = 1'b0; end
         if (!s1 && if1.done_irq_p) begin
            s1 = 1; l1 = cyc - t; y1 = if1.y; e1 = if1.err;
            chk("busy_at_done1", if1.busy, 0);
         end
         if (!s3 && if3.done_irq_p) begin
            s3 = 1; l3 = cyc - t; y3 = if3.y; e3 = if3.err;
            chk("busy_at_done3", if3.busy, 0);
         end
      end
      chk("done_seen1", s1, 1);
      chk("done_seen3", s3, 1);
      if (s1) chk("latency1", l1, ref_lat(is_err, e, 1));
      if (s3) chk("latency3", l3, ref_lat(is_err, e, 3));
      prev_y = is_err ? '0 : ref_pow2(m, e);
   endtask

   vec_t vecs[$];
   logic [NB-1:0] y1, y3, rm, ey;
   bit e1, e3, seen;
   int rms;
   bit rsq;

   initial begin
      vecs.push_back('{64'd13, 4, 1'b0, 64'd3, 1'b0});
      vecs.push_back('{64'd13, 4, 1'b1, 64'd9, 1'b0});
      vecs.push_back('{64'd1, 1, 1'b0, 64'd0, 1'b0});
      vecs.push_back('{64'd0, 4, 1'b0, 64'd0, 1'b1});
      vecs.push_back('{64'd13, 65, 1'b0, 64'd0, 1'b1});
      vecs.push_back('{64'd13, 0, 1'b0, 64'd1, 1'b0});
      vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b0, 64'd1, 1'b0});
      vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b1, 64'd1, 1'b0});
      vecs.push_back('{64'd1000, 10, 1'b0, 64'd24, 1'b0});

      drive('0, 0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      chk("rst_y1", if1.y, 0);
      chk("rst_busy1", if1.busy, 0);
      chk("rst_err1", if1.err, 0);
      chk("rst_done1", if1.done_irq_p, 0);
      chk("rst_busy3", if3.busy, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Back-to-back: each start lands in the previous done cycle of the PBITS=1 instance.
      foreach (vecs[i]) begin
         run_op(vecs[i].m, vecs[i].ms, vecs[i].sq, 1'b0, y1, y3, e1, e3);
         chk($sformatf("vec%0d_y1", i), y1, vecs[i].exp_y);
         chk($sformatf("vec%0d_y3", i), y3, vecs[i].exp_y);
         chk($sformatf("vec%0d_err1", i), e1, vecs[i].exp_err);
         chk($sformatf("vec%0d_err3", i), e3, vecs[i].exp_err);
      end

      run_op(64'd13, 4, 1'b1, 1'b1, y1, y3, e1, e3);
      chk("disturb_y1", y1, 64'd9);
      chk("disturb_y3", y3, 64'd9);

      drive(64'd13, 4, 1'b1, 1'b1);
      @(negedge clk);
      if1.enable_p = 1'b0; if3.enable_p = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst_y1", if1.y, 0);
      chk("midrst_busy1", if1.busy, 0);
      chk("midrst_err1", if1.err, 0);
      chk("midrst_y3", if3.y, 0);
      chk("midrst_busy3", if3.busy, 0);
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (if1.done_irq_p || if3.done_irq_p) seen = 1;
      end
      chk("midrst_no_done", seen, 0);
      prev_y = '0;
      run_op(64'd13, 4, 1'b0, 1'b0, y1, y3, e1, e3);
      chk("after_rst_y1", y1, 64'd3);
      chk("after_rst_y3", y3, 64'd3);

      for (int n = 0; n < 24; n++) begin
         rm = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) rm = 64'($urandom_range(1, 1000));
         rms = $urandom_range(0, 64);
         rsq = 1'($urandom_range(0, 1));
         ey = ref_pow2(rm, rsq ? 2 * rms : rms);
         run_op(rm, rms, rsq, 1'b0, y1, y3, e1, e3);
         chk($sformatf("rand%0d_y1", n), y1, ey);
         chk($sformatf("rand%0d_y3", n), y3, ey);
         chk($sformatf("rand%0d_err1", n), e1, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
